// File: rtl/atr_sequencer_if.sv
// atr_sequencer_if: per-channel ATR control and status bundle between a host and the sequencer.
interface atr_sequencer_if #(
   parameter int NCH = 2,
   parameter int CW  = 16
);
   logic [NCH-1:0]    ena_i;
   logic [NCH-1:0]    tx_empty_i;
   logic [NCH*CW-1:0] tx_delay_i;
   logic [NCH*CW-1:0] rx_delay_i;
   logic [NCH-1:0]    atr_tx_o;
   logic [NCH-1:0]    atr_rx_o;
   logic [NCH-1:0]    busy_o;
   modport master (
      output ena_i, tx_empty_i, tx_delay_i, rx_delay_i,
      input  atr_tx_o, atr_rx_o, busy_o
   );
   modport slave (
      input  ena_i, tx_empty_i, tx_delay_i, rx_delay_i,
      output atr_tx_o, atr_rx_o, busy_o
   );
endinterface

// File: rtl/atr_sequencer.sv
// atr_sequencer: independent per-channel RX/TX antenna switching with programmable turnaround delays.
// Define ATR_DEADBAND_EN to drop atr_rx_o during TX_DELAY so neither path is selected.
module atr_sequencer #(
   parameter int NCH = 2,
   parameter int CW  = 16
) (
   input logic          clk_i,
   input logic          rst_i,
   atr_sequencer_if.slave bus
);
   localparam logic [3:0] ST_RX  = 4'b0001;
   localparam logic [3:0] ST_TXD = 4'b0010;
   localparam logic [3:0] ST_TX  = 4'b0100;
   localparam logic [3:0] ST_RXD = 4'b1000;
   for (genvar n = 0; n < NCH; n++) begin : g_ch
      logic [3:0]    state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          empty, zero;
      assign empty = bus.tx_empty_i[n];
      assign zero  = (cnt_q == '0);
      // cancel/re-key tests come before expiry; disable overrides everything
      always_comb begin
         state_d = ST_RX;
         cnt_d   = '0;
         case (state_q)
            ST_RX: begin
               state_d = empty ? ST_RX : ST_TXD;
               cnt_d   = empty ? '0 : bus.tx_delay_i[n*CW +: CW];
            end
            ST_TXD: begin
               state_d = empty ? ST_RX : (zero ? ST_TX : ST_TXD);
               cnt_d   = (empty || zero) ? '0 : cnt_q - CW'(1);
            end
            ST_TX: begin
               state_d = empty ? ST_RXD : ST_TX;
               cnt_d   = empty ? bus.rx_delay_i[n*CW +: CW] : '0;
            end
            ST_RXD: begin
               state_d = !empty ? ST_TX : (zero ? ST_RX : ST_RXD);
               cnt_d   = (!empty || zero) ? '0 : cnt_q - CW'(1);
            end
            default: ;
         endcase
         if (!bus.ena_i[n]) begin
            state_d = ST_RX;
            cnt_d   = '0;
         end
      end
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            state_q <= ST_RX;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
         end
      end
      assign bus.atr_tx_o[n] = state_q[2] | state_q[3];
      assign bus.busy_o[n]   = state_q[1] | state_q[3];
`ifdef ATR_DEADBAND_EN
      assign bus.atr_rx_o[n] = state_q[0];
`else
      assign bus.atr_rx_o[n] = ~(state_q[2] | state_q[3]);
`endif
   end
endmodule

// File: tb/tb_atr_sequencer.sv
// tb_atr_sequencer: directed vectors feed an expected-output queue; a monitor checks every cycle.
module tb_atr_sequencer;
   localparam int NCH = 2;
   localparam int CW  = 16;
   typedef struct {
      logic [1:0] tx;
      logic [1:0] rx;
      logic [1:0] busy;
      string      name;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [CW-1:0] td0 = '0, rd0 = '0, td1 = '0, rd1 = '0;
   exp_t sb[$];
   int compared = 0;
   int mismatched = 0;
   atr_sequencer_if #(.NCH(NCH), .CW(CW)) bus ();
   atr_sequencer #(.NCH(NCH), .CW(CW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));
   always #5 clk = ~clk;
   // apply one cycle of inputs at the falling edge; expect outputs after the next rising edge
   task automatic step(input logic r, input logic [1:0] en, input logic [1:0] emp,
                       input logic [1:0] etx, input logic [1:0] ebusy, input string nm);
      exp_t e;
      @(negedge clk);
      rst = r;
      bus.ena_i = en;
      bus.tx_empty_i = emp;
      bus.tx_delay_i = {td1, td0};
      bus.rx_delay_i = {rd1, rd0};
      e.tx = etx;
      e.busy = ebusy;
`ifdef ATR_DEADBAND_EN
      e.rx = ~(etx | ebusy);
`else
      e.rx = ~etx;
`endif
      e.name = nm;
      sb.push_back(e);
   endtask
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            compared++;
            if ({bus.atr_tx_o, bus.atr_rx_o, bus.busy_o} !== {e.tx, e.rx, e.busy}) begin
               mismatched++;
               $display("FAIL %s: got tx=%b rx=%b busy=%b, expected tx=%b rx=%b busy=%b",
                        e.name, bus.atr_tx_o, bus.atr_rx_o, bus.busy_o, e.tx, e.rx, e.busy);
            end
         end
      end
   end
   initial begin
      bus.ena_i = 2'b11;
      bus.tx_empty_i = 2'b11;
      bus.tx_delay_i = '0;
      bus.rx_delay_i = '0;
      step(1, 2'b11, 2'b11, 2'b00, 2'b00, "reset0");
      step(1, 2'b11, 2'b11, 2'b00, 2'b00, "reset1");
      step(0, 2'b11, 2'b11, 2'b00, 2'b00, "idle");
      // tx_delay 3 gives four busy cycles before TX
      td0 = 16'd3;
      step(0, 2'b11, 2'b10, 2'b00, 2'b01, "txd_c3");
      step(0, 2'b11, 2'b10, 2'b00, 2'b01, "txd_c2");
      step(0, 2'b11, 2'b10, 2'b00, 2'b01, "txd_c1");
      step(0, 2'b11, 2'b10, 2'b00, 2'b01, "txd_c0");
      step(0, 2'b11, 2'b10, 2'b01, 2'b00, "tx_on");
      step(0, 2'b11, 2'b10, 2'b01, 2'b00, "tx_hold");
      // rx_delay 5 interrupted by re-key after two cycles
      rd0 = 16'd5;
      step(0, 2'b11, 2'b11, 2'b01, 2'b01, "rxd_c5");
      step(0, 2'b11, 2'b11, 2'b01, 2'b01, "rxd_c4");
      step(0, 2'b11, 2'b10, 2'b01, 2'b00, "rekey_tx");
      step(0, 2'b11, 2'b10, 2'b01, 2'b00, "rekey_hold");
      // zero delays: one cycle in each delay state
      rd0 = 16'd0;
      td0 = 16'd0;
      step(0, 2'b11, 2'b11, 2'b01, 2'b01, "rxd0");
      step(0, 2'b11, 2'b11, 2'b00, 2'b00, "rx_after_rxd0");
      step(0, 2'b11, 2'b10, 2'b00, 2'b01, "txd0");
      step(0, 2'b11, 2'b10, 2'b01, 2'b00, "tx_after_txd0");
      step(0, 2'b11, 2'b11, 2'b01, 2'b01, "rxd0_b");
      step(0, 2'b11, 2'b11, 2'b00, 2'b00, "rx_b");
      // tx_delay 8 loaded, then changed to 2 mid-delay: still nine busy cycles
      td0 = 16'd8;
      step(0, 2'b11, 2'b10, 2'b00, 2'b01, "txd8_load");
      td0 = 16'd2;
      for (int i = 0; i < 8; i++) step(0, 2'b11, 2'b10, 2'b00, 2'b01, "txd8_run");
      step(0, 2'b11, 2'b10, 2'b01, 2'b00, "txd8_tx");
      // channel 1 cancels a 10-cycle delay on its fourth cycle; channel 0 stays in TX
      td1 = 16'd10;
      step(0, 2'b11, 2'b00, 2'b01, 2'b10, "ch1_txd_c10");
      step(0, 2'b11, 2'b00, 2'b01, 2'b10, "ch1_txd_c9");
      step(0, 2'b11, 2'b00, 2'b01, 2'b10, "ch1_txd_c8");
      step(0, 2'b11, 2'b00, 2'b01, 2'b10, "ch1_txd_c7");
      step(0, 2'b11, 2'b10, 2'b01, 2'b00, "ch1_cancel");
      step(0, 2'b11, 2'b10, 2'b01, 2'b00, "ch1_stay_rx");
      // reset pulse in RX_DELAY with count 7
      rd0 = 16'd7;
      step(0, 2'b11, 2'b11, 2'b01, 2'b01, "rxd7");
      step(0, 2'b11, 2'b11, 2'b01, 2'b01, "rxd6");
      step(1, 2'b11, 2'b11, 2'b00, 2'b00, "rst_mid_rxd");
      step(0, 2'b11, 2'b11, 2'b00, 2'b00, "rst_no_residual");
      step(0, 2'b11, 2'b11, 2'b00, 2'b00, "rst_no_residual2");
      // enable drop in RX_DELAY, also overriding a simultaneous re-key
      td0 = 16'd0;
      step(0, 2'b11, 2'b10, 2'b00, 2'b01, "txd_re");
      step(0, 2'b11, 2'b10, 2'b01, 2'b00, "tx_re");
      step(0, 2'b11, 2'b11, 2'b01, 2'b01, "rxd7_b");
      step(0, 2'b10, 2'b10, 2'b00, 2'b00, "ena_off");
      step(0, 2'b10, 2'b10, 2'b00, 2'b00, "ena_off_hold");
      step(0, 2'b11, 2'b11, 2'b00, 2'b00, "ena_on_rx");
      step(0, 2'b11, 2'b11, 2'b00, 2'b00, "ena_on_rx2");
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      #2;
      if (sb.size() > 0) begin
         mismatched++;
         $display("FAIL drain: %0d expected entries left, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/atr_sequencer.md
ATR_SEQUENCER -- requirements
Module: atr_sequencer

Interface
REQ-001 SHALL have parameter NCH, default 2: number of independent ATR channels (1..8).
REQ-002 SHALL have parameter CW, default 16: delay counter width in bits (4..24).
REQ-003 SHALL have port clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ena_i  input  NCH  per-channel enable; bit n controls channel n.
REQ-006 SHALL have port tx_empty_i  input  NCH  per-channel TX FIFO empty flag.
REQ-007 SHALL have port tx_delay_i  input  NCH*CW  per-channel RX-to-TX delay in cycles; channel n at bits [n*CW +: CW].
REQ-008 SHALL have port rx_delay_i  input  NCH*CW  per-channel TX-to-RX delay in cycles; same packing.
REQ-009 SHALL have port atr_tx_o  output  NCH  per-channel transmit-select.
REQ-010 SHALL have port atr_rx_o  output  NCH  per-channel receive-select.
REQ-011 SHALL have port busy_o  output  NCH  per-channel high while in either delay state.

Function
REQ-012 SHALL run one one-hot state machine and one CW-bit counter per channel; channels share no state.
REQ-013 SHALL use states RX, TX_DELAY, TX, RX_DELAY.
REQ-014 RX: tx_empty_i[n]=0 -> TX_DELAY, counter loads tx_delay_i[n]; else stay.
REQ-015 TX_DELAY: tx_empty_i[n]=1 -> RX (cancel, counter cleared); else counter==0 -> TX; else counter decrements by 1.
REQ-016 TX: tx_empty_i[n]=1 -> RX_DELAY, counter loads rx_delay_i[n]; else stay.
REQ-017 RX_DELAY: tx_empty_i[n]=0 -> TX (re-key, no TX delay); else counter==0 -> RX; else counter decrements by 1.
REQ-018 Delay value D SHALL yield exactly D+1 cycles in the delay state when uninterrupted; D=0 gives one cycle.
REQ-019 Cancel/re-key checks (REQ-015, REQ-017) SHALL take priority over counter expiry in the same cycle.
REQ-020 Delay inputs SHALL be sampled only at the load edge; changes during a delay SHALL not affect it.
REQ-021 Counter SHALL never decrement below zero nor wrap.
REQ-022 atr_tx_o[n] SHALL be high in TX or RX_DELAY; decoded from the state register, no added latency.
REQ-023 busy_o[n] SHALL be high in TX_DELAY or RX_DELAY.
REQ-024 ena_i[n]=0 SHALL force channel n to RX with counter 0 at the next edge, from any state, overriding all transitions.
REQ-025 Any non-one-hot state SHALL return to RX with counter 0 at the next edge.

Reset
REQ-026 rst_i=1 SHALL, at the next edge, put all channels in RX with counter 0.
REQ-027 During and after reset: atr_tx_o=0, atr_rx_o=all ones, busy_o=0.
REQ-028 Reset mid-delay SHALL abandon the delay; no residual count after release.

Configuration
REQ-029 Macro ATR_DEADBAND_EN SHALL select atr_rx_o decoding.
REQ-030 With ATR_DEADBAND_EN defined: atr_rx_o[n] high only in RX; both outputs low in TX_DELAY.
REQ-031 Without it: atr_rx_o[n] = ~atr_tx_o[n] in every state.

Verification
REQ-032 NCH=2, CW=16, tx_delay[0]=3, tx_empty[0] falls at edge k -> atr_tx_o[0] rises after edge k+5, busy_o[0] high edges k+1..k+4.
REQ-033 Channel 0 in TX, rx_delay=5, tx_empty rises; after 2 cycles tx_empty falls -> direct to TX, atr_tx_o[0] never drops, busy_o[0] low.
REQ-034 Channel 1 in TX_DELAY, tx_delay=10; tx_empty[1] reasserts at cycle 4 -> RX next edge, atr_tx_o[1] never rises; channel 0 undisturbed.
REQ-035 tx_delay=0 and rx_delay=0 -> exactly one cycle in each delay state; mid-delay change of tx_delay_i from 8 to 2 keeps 9-cycle delay.
REQ-036 rst_i or ena_i[0]=0 pulsed in RX_DELAY with count 7 -> RX next edge, atr_tx_o[0]=0, busy_o[0]=0; no re-entry to delay.
REQ-037 Build with and without ATR_DEADBAND_EN -> atr_rx_o in TX_DELAY is 0 and 1 respectively; identical elsewhere.
